// File: rtl/fpr_ctx_xfer_if.sv
// fpr_ctx_xfer_if: bundle of context-transfer control, FPR register-file ports and memory port
// master: the sequencer (drives register ids, write data and memory requests)
// slave:  the environment (register file, memory and the trap/context-switch requester)
interface fpr_ctx_xfer_if;
  logic ctxStart;
  logic ctxDir;
  logic ctxWide;
  logic [31:0] ctxBase;
  logic ctxBusy;
  logic ctxDone;
  logic [31:0] ctxSum;
  logic [6:0] fprIdRd;
  logic [1:0] fprModeRd;
  logic [63:0] fprValRd;
  logic [6:0] fprIdWr;
  logic [63:0] fprValWr;
  logic [1:0] fprStModeWr;
  logic memReq;
  logic memWr;
  logic memWide;
  logic [31:0] memAddr;
  logic [63:0] memDataOut;
  logic [63:0] memDataIn;
  logic memOk;
  modport master (
    input ctxStart, ctxDir, ctxWide, ctxBase, fprValRd, memDataIn, memOk,
    output ctxBusy, ctxDone, ctxSum, fprIdRd, fprModeRd, fprIdWr, fprValWr, fprStModeWr,
    output memReq, memWr, memWide, memAddr, memDataOut
  );
  modport slave (
    output ctxStart, ctxDir, ctxWide, ctxBase, fprValRd, memDataIn, memOk,
    input ctxBusy, ctxDone, ctxSum, fprIdRd, fprModeRd, fprIdWr, fprValWr, fprStModeWr,
    input memReq, memWr, memWide, memAddr, memDataOut
  );
endinterface

// File: rtl/fpr_ctx_xfer.sv
// fpr_ctx_xfer: FPU context save/restore sequencer driving the FPR read/write ports and memory
// Ports:
//   clock  rising-edge clock
//   reset  asynchronous active-low reset; abandons any sequence in flight
//   bus    fpr_ctx_xfer_if.master: ctxStart/ctxDir/ctxWide/ctxBase in, ctxBusy/ctxDone/ctxSum out,
//          FPR read port (fprIdRd/fprModeRd/fprValRd), FPR write port (fprIdWr/fprValWr/fprStModeWr),
//          memory port (memReq/memWr/memWide/memAddr/memDataOut/memDataIn/memOk)
// Option: define FPR_CTX_CHKSUM_EN to build the ctxSum transfer checksum; otherwise ctxSum is 0.
module fpr_ctx_xfer #(
  parameter logic [6:0] FR_BASE = 7'h20,
  parameter logic [6:0] XF_BASE = 7'h30,
  parameter logic [6:0] FPUL_ID = 7'h12,
  parameter logic [6:0] NULL_ID = 7'h7F
) (
  input logic clock,
  input logic reset,
  fpr_ctx_xfer_if.master bus
);
  typedef enum logic [2:0] {IDLE, SAVE, LOAD, WRBACK, FIN} state_t;
  state_t state, stateNx;
  logic wide;
  logic [31:0] base;
  logic [5:0] idx;
  logic [63:0] capData;
  logic isFpul;
  logic pairWide;
  logic [6:0] curId;
  logic [31:0] curAddr;
  logic [63:0] rdData;
  logic [63:0] ldData;
  // The FPUL slot is idx 16 (wide) or 32 (narrow), the only index with that bit set.
  // Narrow ids 16..31 land on XF0..XF15 through idx[4]; wide mode never reaches idx[4] before FPUL.
  always_comb begin
    isFpul = wide ? idx[4] : idx[5];
    pairWide = wide && !isFpul;
    curId = isFpul ? FPUL_ID : (idx[4] ? XF_BASE : FR_BASE) + {3'd0, idx[3:0]};
    curAddr = base + (wide ? {23'd0, idx, 3'd0} : {24'd0, idx, 2'd0});
    rdData = pairWide ? bus.fprValRd : {32'd0, bus.fprValRd[31:0]};
    ldData = pairWide ? bus.memDataIn : {32'd0, bus.memDataIn[31:0]};
  end
  always_comb begin
    stateNx = state;
    case (state)
      IDLE: if (bus.ctxStart) stateNx = bus.ctxDir ? LOAD : SAVE;
      SAVE: if (bus.memOk) stateNx = isFpul ? FIN : SAVE;
      LOAD: if (bus.memOk) stateNx = WRBACK;
      WRBACK: stateNx = isFpul ? FIN : LOAD;
      default: stateNx = IDLE;
    endcase
  end
  // All port outputs decode from the registered state, so an asserted reset idles them at once.
  always_comb begin
    bus.ctxBusy = state inside {SAVE, LOAD, WRBACK};
    bus.ctxDone = state == FIN;
    bus.fprIdRd = state == SAVE ? curId : NULL_ID;
    bus.fprModeRd = {1'b0, state == SAVE && pairWide};
    bus.memReq = state inside {SAVE, LOAD};
    bus.memWr = state == SAVE;
    bus.memWide = bus.memReq && pairWide;
    bus.memAddr = bus.memReq ? curAddr : 32'd0;
    bus.memDataOut = state == SAVE ? rdData : 64'd0;
    bus.fprIdWr = state == WRBACK ? curId : NULL_ID;
    bus.fprValWr = state == WRBACK ? capData : 64'd0;
    bus.fprStModeWr = {1'b0, state == WRBACK && pairWide};
  end
  always_ff @(posedge clock or negedge reset)
    if (!reset) state <= IDLE;
    else state <= stateNx;
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      wide <= 1'b0;
      base <= 32'd0;
      idx <= 6'd0;
      capData <= 64'd0;
    end else begin
      if (state == IDLE && bus.ctxStart) begin
        wide <= bus.ctxWide;
        base <= bus.ctxBase;
        idx <= 6'd0;
      end
      if ((state == SAVE && bus.memOk) || state == WRBACK) idx <= idx + 6'd1;
      if (state == LOAD && bus.memOk) capData <= ldData;
    end
`ifdef FPR_CTX_CHKSUM_EN
  logic [31:0] sum;
  always_ff @(posedge clock or negedge reset)
    if (!reset) sum <= 32'd0;
    else if (state == IDLE && bus.ctxStart) sum <= 32'd0;
    else if (state == SAVE && bus.memOk) sum <= sum ^ rdData[31:0] ^ rdData[63:32];
    else if (state == WRBACK) sum <= sum ^ capData[31:0] ^ capData[63:32];
  assign bus.ctxSum = sum;
`else
  assign bus.ctxSum = 32'd0;
`endif
endmodule

// File: tb/tb_fpr_ctx_xfer.sv
// tb_fpr_ctx_xfer: table-driven and randomized bench for fpr_ctx_xfer with register-file and memory models
module tb_fpr_ctx_xfer;
  localparam logic [6:0] FR_BASE = 7'h20;
  localparam logic [6:0] XF_BASE = 7'h30;
  localparam logic [6:0] FPUL_ID = 7'h12;
  localparam logic [6:0] NULL_ID = 7'h7F;
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;
  fpr_ctx_xfer_if bus();
  fpr_ctx_xfer #(.FR_BASE(FR_BASE), .XF_BASE(XF_BASE), .FPUL_ID(FPUL_ID), .NULL_ID(NULL_ID))
    dut (.clock(clock), .reset(reset), .bus(bus));
  int nChecks = 0;
  int nFail = 0;
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask
  // register file and memory image
  logic [31:0] fr [16];
  logic [31:0] xf [16];
  logic [31:0] fpul;
  logic [63:0] memImg [64];
  logic [31:0] junk = 32'hDEAD_BEEF;
  logic [31:0] tbBase = 32'd0;
  logic tbWide = 1'b0;
  int stall = 0;
  logic [6:0] rdOff, xfOff;
  assign rdOff = bus.fprIdRd - FR_BASE;
  assign xfOff = bus.fprIdRd - XF_BASE;
  // wide reads of FRn: even n -> {FRn, FRn+1}, odd n -> {XFn-1, XFn}; narrow reads carry junk above bit 31
  always_comb begin
    bus.fprValRd = {junk, junk};
    if (rdOff < 7'd16) begin
      if (!bus.fprModeRd[0]) bus.fprValRd = {junk, fr[rdOff[3:0]]};
      else if (rdOff[0]) bus.fprValRd = {xf[rdOff[3:0] - 4'd1], xf[rdOff[3:0]]};
      else bus.fprValRd = {fr[rdOff[3:0]], fr[rdOff[3:0] + 4'd1]};
    end else if (xfOff < 7'd16) bus.fprValRd = {junk, xf[xfOff[3:0]]};
    else if (bus.fprIdRd == FPUL_ID) bus.fprValRd = {junk, fpul};
  end
  logic [31:0] memOff;
  logic [5:0] slot;
  assign memOff = bus.memAddr - tbBase;
  assign slot = tbWide ? memOff[8:3] : memOff[7:2];
  always_comb bus.memDataIn = (tbWide && slot < 6'd16) ? memImg[slot] : {junk, memImg[slot][31:0]};
  // memory handshake: each request waits `stall` cycles; memOk toggles randomly when nothing is requested
  int waitCnt = 0;
  always @(negedge clock) begin
    junk = $urandom;
    if (bus.memReq) begin
      if (waitCnt >= stall) begin
        bus.memOk = 1'b1;
        waitCnt = 0;
      end else begin
        bus.memOk = 1'b0;
        waitCnt++;
      end
    end else begin
      bus.memOk = 1'($urandom_range(0, 1));
      waitCnt = 0;
    end
  end
  // monitor: records completed memory transfers and write-port pulses; checks stalled requests hold
  typedef struct packed {logic wr; logic wide; logic [31:0] addr; logic [63:0] data;} memEv_t;
  typedef struct packed {logic [6:0] id; logic [1:0] mode; logic [63:0] data;} wrEv_t;
  memEv_t memQ[$];
  wrEv_t wrQ[$];
  logic prevStall = 1'b0;
  logic prevWr;
  logic [31:0] prevAddr;
  logic [63:0] prevData;
  always @(negedge clock) begin
    #2;
    if (!reset) prevStall = 1'b0;
    else begin
      if (prevStall) begin
        check("stallReq", bus.memReq, 1);
        check("stallWr", bus.memWr, prevWr);
        check("stallAddr", bus.memAddr, prevAddr);
        check("stallData", bus.memDataOut, prevData);
      end
      if (bus.memReq && bus.memOk)
        memQ.push_back('{wr: bus.memWr, wide: bus.memWide, addr: bus.memAddr,
                         data: bus.memWr ? bus.memDataOut : bus.memDataIn});
      if (bus.fprIdWr != NULL_ID) wrQ.push_back('{id: bus.fprIdWr, mode: bus.fprStModeWr, data: bus.fprValWr});
      prevStall = bus.memReq && !bus.memOk;
      prevWr = bus.memWr;
      prevAddr = bus.memAddr;
      prevData = bus.memDataOut;
    end
  end
  // reference transfer list built from the architectural register order
  typedef struct {logic [6:0] id; logic wide; logic [31:0] addr; logic [63:0] sv; logic [63:0] rs;} xfer_t;
  xfer_t expQ[$];
  task automatic buildExp(input logic wide, input logic [31:0] base);
    int n;
    int stride;
    xfer_t t;
    n = wide ? 16 : 32;
    stride = wide ? 8 : 4;
    expQ.delete();
    for (int k = 0; k <= n; k++) begin
      t.addr = base + k * stride;
      t.wide = wide && k < n;
      if (k == n) begin
        t.id = FPUL_ID;
        t.sv = {32'd0, fpul};
      end else if (k < 16) begin
        t.id = FR_BASE + 7'(k);
        if (!wide) t.sv = {32'd0, fr[k]};
        else if (k % 2 == 1) t.sv = {xf[k - 1], xf[k]};
        else t.sv = {fr[k], fr[k + 1]};
      end else begin
        t.id = XF_BASE + 7'(k - 16);
        t.sv = {32'd0, xf[k - 16]};
      end
      t.rs = t.wide ? memImg[k] : {32'd0, memImg[k][31:0]};
      expQ.push_back(t);
    end
  endtask
  task automatic checkIdle(input string tag);
    check({tag, ".busy"}, bus.ctxBusy, 0);
    check({tag, ".done"}, bus.ctxDone, 0);
    check({tag, ".memReq"}, bus.memReq, 0);
    check({tag, ".memWr"}, bus.memWr, 0);
    check({tag, ".memWide"}, bus.memWide, 0);
    check({tag, ".memAddr"}, bus.memAddr, 0);
    check({tag, ".memDataOut"}, bus.memDataOut, 0);
    check({tag, ".fprValWr"}, bus.fprValWr, 0);
    check({tag, ".ctxSum"}, bus.ctxSum, 0);
    check({tag, ".fprIdRd"}, bus.fprIdRd, NULL_ID);
    check({tag, ".fprIdWr"}, bus.fprIdWr, NULL_ID);
    check({tag, ".fprModeRd"}, bus.fprModeRd, 0);
    check({tag, ".fprStModeWr"}, bus.fprStModeWr, 0);
  endtask
  typedef struct {
    logic dir; logic wide; logic [31:0] base; int stall; logic rnd; int glitchAt; int nXfer; int doneAt;
  } vec_t;
  vec_t vecs[7];
  task automatic runVec(input int vi, input vec_t v);
    int cyc;
    logic seen;
    logic [31:0] expSum;
    logic [63:0] d;
    if (v.rnd) begin
      for (int i = 0; i < 16; i++) begin
        fr[i] = $urandom;
        xf[i] = $urandom;
      end
      fpul = $urandom;
      for (int i = 0; i < 64; i++) memImg[i] = {$urandom, $urandom};
    end
    buildExp(v.wide, v.base);
    memQ.delete();
    wrQ.delete();
    @(negedge clock);
    tbBase = v.base;
    tbWide = v.wide;
    stall = v.stall;
    bus.ctxStart = 1'b1;
    bus.ctxDir = v.dir;
    bus.ctxWide = v.wide;
    bus.ctxBase = v.base;
    @(negedge clock);
    bus.ctxStart = 1'b0;
    bus.ctxDir = ~v.dir;
    bus.ctxWide = ~v.wide;
    bus.ctxBase = $urandom;
    cyc = 0;
    seen = 1'b0;
    while (!seen && cyc < 2000) begin
      #3;
      cyc++;
      if (cyc == 1) check($sformatf("v%0d.busyStart", vi), bus.ctxBusy, 1);
      if (v.glitchAt > 0 && cyc == v.glitchAt) begin
        bus.ctxStart = 1'b1;
        bus.ctxDir = ~v.dir;
        bus.ctxBase = v.base ^ 32'h0000_0800;
      end
      if (v.glitchAt > 0 && cyc == v.glitchAt + 1) bus.ctxStart = 1'b0;
      if (bus.ctxDone) seen = 1'b1;
      else @(negedge clock);
    end
    check($sformatf("v%0d.doneAt", vi), cyc, v.doneAt);
    check($sformatf("v%0d.busyAtDone", vi), bus.ctxBusy, 0);
    bus.ctxStart = 1'b1;
    @(negedge clock);
    bus.ctxStart = 1'b0;
    #3;
    check($sformatf("v%0d.finStartIgnored", vi), bus.ctxBusy, 0);
    check($sformatf("v%0d.doneOnePulse", vi), bus.ctxDone, 0);
    check($sformatf("v%0d.nMem", vi), memQ.size(), v.nXfer);
    check($sformatf("v%0d.nWr", vi), wrQ.size(), v.dir ? v.nXfer : 0);
    expSum = 32'd0;
    foreach (expQ[k]) begin
      d = v.dir ? expQ[k].rs : expQ[k].sv;
      expSum ^= d[31:0] ^ d[63:32];
      if (k < memQ.size()) begin
        check($sformatf("v%0d.addr[%0d]", vi, k), memQ[k].addr, expQ[k].addr);
        check($sformatf("v%0d.wr[%0d]", vi, k), memQ[k].wr, !v.dir);
        check($sformatf("v%0d.wide[%0d]", vi, k), memQ[k].wide, expQ[k].wide);
        if (!v.dir) check($sformatf("v%0d.data[%0d]", vi, k), memQ[k].data, expQ[k].sv);
      end
      if (v.dir && k < wrQ.size()) begin
        check($sformatf("v%0d.wrId[%0d]", vi, k), wrQ[k].id, expQ[k].id);
        check($sformatf("v%0d.wrMode[%0d]", vi, k), wrQ[k].mode, {1'b0, expQ[k].wide});
        check($sformatf("v%0d.wrData[%0d]", vi, k), wrQ[k].data, expQ[k].rs);
      end
    end
`ifdef FPR_CTX_CHKSUM_EN
    check($sformatf("v%0d.ctxSum", vi), bus.ctxSum, expSum);
`else
    check($sformatf("v%0d.ctxSum", vi), bus.ctxSum, 0);
`endif
    if (!v.dir) foreach (expQ[k]) memImg[k] = expQ[k].sv;
  endtask
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  initial begin
    int cyc;
    bus.ctxStart = 1'b0;
    bus.ctxDir = 1'b0;
    bus.ctxWide = 1'b0;
    bus.ctxBase = 32'd0;
    bus.memOk = 1'b0;
    for (int i = 0; i < 16; i++) begin
      fr[i] = 32'h1000 + i;
      xf[i] = 32'h2000 + i;
    end
    fpul = 32'hCAFE;
    for (int i = 0; i < 64; i++) memImg[i] = 64'd0;
    vecs[0] = '{1'b0, 1'b0, 32'h100, 0, 1'b0, 0, 33, 34};
    vecs[1] = '{1'b1, 1'b0, 32'h100, 3, 1'b0, 0, 33, 166};
    vecs[2] = '{1'b0, 1'b1, 32'h100, 0, 1'b0, 0, 17, 18};
    vecs[3] = '{1'b1, 1'b1, 32'h2000, 1, 1'b0, 0, 17, 52};
    vecs[4] = '{1'b0, 1'b0, 32'h3000, 2, 1'b1, 0, 33, 100};
    vecs[5] = '{1'b1, 1'b0, 32'hFFFF_FF80, 0, 1'b1, 0, 33, 67};
    vecs[6] = '{1'b0, 1'b0, 32'h100, 1, 1'b1, 10, 33, 67};
    #1 reset = 1'b0;
    repeat (2) @(negedge clock);
    #3 checkIdle("reset");
    @(negedge clock);
    reset = 1'b1;
    for (int i = 0; i < 7; i++) begin
      runVec(i, vecs[i]);
      if (i == 0 && memQ.size() == 33) begin
        check("narrow.fpulAddr", memQ[32].addr, 32'h180);
        check("narrow.fpulData", memQ[32].data, 64'h0000_0000_0000_CAFE);
        check("narrow.xf0Data", memQ[16].data, 64'h0000_0000_0000_2000);
      end
      if (i == 2 && memQ.size() == 17) begin
        check("wide.pairAddr", memQ[1].addr, 32'h108);
        check("wide.pairData", memQ[1].data, 64'h0000_2000_0000_2001);
        check("wide.fpulAddr", memQ[16].addr, 32'h180);
        check("wide.fpulData", memQ[16].data, 64'h0000_0000_0000_CAFE);
      end
    end
    // abort a narrow restore after five register writes
    memQ.delete();
    wrQ.delete();
    @(negedge clock);
    tbBase = 32'h100;
    tbWide = 1'b0;
    stall = 0;
    bus.ctxStart = 1'b1;
    bus.ctxDir = 1'b1;
    bus.ctxWide = 1'b0;
    bus.ctxBase = 32'h100;
    @(negedge clock);
    bus.ctxStart = 1'b0;
    cyc = 0;
    while (wrQ.size() < 5 && cyc < 300) begin
      #3;
      cyc++;
      if (wrQ.size() < 5) @(negedge clock);
    end
    check("abort.writesSeen", wrQ.size(), 5);
    reset = 1'b0;
    #1 checkIdle("abort");
    repeat (3) begin
      @(negedge clock);
      #3 check("abort.noWrite", bus.fprIdWr, NULL_ID);
    end
    reset = 1'b1;
    check("abort.noLateWrite", wrQ.size(), 5);
    runVec(7, vecs[1]);
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end
endmodule
